// File: rtl/or1200_dc_maint_pkg.sv
// Shared types and SPR sub-addresses for the data-cache block maintenance sequencer.
package or1200_dc_maint_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StRelease,
    StAbort,
    StAck,
    StWait
  } dc_maint_state_e;

  typedef enum logic {
    OpFlush,
    OpWriteback
  } dc_maint_op_e;

  // SPR sub-addresses inside the DC maintenance group
  localparam logic [2:0] SPR_DCBFR = 3'd2;
  localparam logic [2:0] SPR_DCBWR = 3'd4;
  localparam logic [2:0] SPR_DCRNG = 3'd6;

  // True for the sub-addresses that start a block operation
  function automatic logic is_block_op(logic [2:0] sub_addr);
    return (sub_addr == SPR_DCBFR) || (sub_addr == SPR_DCBWR);
  endfunction

endpackage

// File: rtl/or1200_dc_maint_wdog.sv
// Watchdog for one block op: cleared while idle, counts while enabled, flags the last
// allowed cycle. With TIMEOUT=0 the counter is removed and expiry never fires.
module or1200_dc_maint_wdog #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  if (TIMEOUT == 0) begin : g_off
    logic unused_wdog;
    assign unused_wdog = ^{clk, rst, clr_i, en_i};
    assign expired_o   = 1'b0;
  end else begin : g_on
    localparam int unsigned W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);
    localparam logic [W-1:0] ONE  = W'(1);

    logic [W-1:0] cnt_q, cnt_d;

    // Saturate at LAST so the counter can never wrap back through zero
    always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
        cnt_d = '0;
      end else if (en_i && (cnt_q != LAST)) begin
        cnt_d = cnt_q + ONE;
      end
    end

    // Counter register
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    assign expired_o = en_i && (cnt_q == LAST);
  end

endmodule

// File: rtl/or1200_dc_maint_seq.sv
// Block flush/writeback sequencer between the SPR bus and the DC FSM.
// Optional feature: define OR1200_DC_MAINT_RANGE_EN to enable the DCRNG range register
// so one flush/writeback walks range+1 consecutive lines.
module or1200_dc_maint_seq
  import or1200_dc_maint_pkg::*;
#(
  parameter int unsigned LINE_BYTES = 16,
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        spr_cs_i,
  input  logic        spr_write_i,
  input  logic [2:0]  spr_addr_i,
  input  logic [31:0] spr_dat_i,
  output logic        spr_ack_o,
  output logic        busy_o,
  output logic        err_o,
  output logic        dc_spr_cswe_o,
  output logic        dc_block_flush_o,
  output logic        dc_block_writeback_o,
  output logic [31:0] dc_addr_o,
  input  logic        mtspr_dc_done_i
);

  localparam logic [31:0]      LINE_MASK = 32'(LINE_BYTES - 1);
  localparam logic [31:0]      LINE_STEP = 32'(LINE_BYTES);
  localparam logic [CNT_W-1:0] REM_ONE   = CNT_W'(1);

  dc_maint_state_e  state_q, state_d;
  dc_maint_op_e     op_q, op_d;
  logic [31:0]      addr_q, addr_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] range_val;
  logic             wd_expired;

`ifdef OR1200_DC_MAINT_RANGE_EN
  logic [CNT_W-1:0] range_q, range_d;

  // Range register persists across ops until reset or the next DCRNG write
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      range_q <= '0;
    end else begin
      range_q <= range_d;
    end
  end

  assign range_val = range_q;
`else
  assign range_val = '0;
`endif

  // Watchdog is held clear outside ISSUE, so every entry to ISSUE restarts it
  or1200_dc_maint_wdog #(
    .TIMEOUT(TIMEOUT)
  ) u_wdog (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (state_q != StIssue),
    .en_i      (state_q == StIssue),
    .expired_o (wd_expired)
  );

  // Next-state and datapath updates
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    err_d   = err_q;
`ifdef OR1200_DC_MAINT_RANGE_EN
    range_d = range_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (spr_cs_i) begin
          if (spr_write_i && is_block_op(spr_addr_i)) begin
            op_d    = (spr_addr_i == SPR_DCBFR) ? OpFlush : OpWriteback;
            addr_d  = spr_dat_i & ~LINE_MASK;
            rem_d   = range_val;
            err_d   = 1'b0;
            state_d = StIssue;
          end else begin
`ifdef OR1200_DC_MAINT_RANGE_EN
            if (spr_write_i && (spr_addr_i == SPR_DCRNG)) begin
              range_d = spr_dat_i[CNT_W-1:0];
            end
`endif
            state_d = StAck;
          end
        end
      end
      StIssue: begin
        // Done takes priority over a watchdog expiry in the same cycle
        if (mtspr_dc_done_i) begin
          state_d = StRelease;
        end else if (wd_expired) begin
          err_d   = 1'b1;
          state_d = StAbort;
        end
      end
      StRelease: begin
        if (rem_q == '0) begin
          state_d = StAck;
        end else begin
          addr_d  = addr_q + LINE_STEP;
          rem_d   = rem_q - REM_ONE;
          state_d = StIssue;
        end
      end
      StAbort: state_d = StAck;
      StAck:   state_d = StWait;
      StWait: begin
        // Hold here until the CPU drops cs so the same access is not taken twice
        if (!spr_cs_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      op_q    <= OpFlush;
      addr_q  <= '0;
      rem_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      err_q   <= err_d;
    end
  end

  // Outputs decoded from registered state only
  always_comb begin
    spr_ack_o            = (state_q == StAck);
    busy_o               = !((state_q == StIdle) || (state_q == StWait));
    err_o                = err_q;
    dc_spr_cswe_o        = (state_q == StIssue);
    dc_block_flush_o     = (state_q == StIssue) && (op_q == OpFlush);
    dc_block_writeback_o = (state_q == StIssue) && (op_q == OpWriteback);
    dc_addr_o            = addr_q;
  end

endmodule
